l1i_axi_bridge: RTL and testbench
=================================

// Module: l1i_axi_bridge
// PURPOSE
//  Memory-side stage below the L1 instruction cache. Turns the cache's I_req/I_wait word
//  interface into AXI4 master transactions: line refills become reads, write-throughs become
//  single writes. Holds one outstanding transaction; the cache stalls on I_wait until done.
// PARAMETERS
//  ID_W      4       AXI ID width
//  MST_ID    4'h0    constant ARID/AWID value
//  LINE_WORDS 4      words per refill (ARLEN = LINE_WORDS-1)
// PORTS
//  ACLK      in   1   clock, all logic on posedge
//  ARESETn   in   1   asynchronous active-low reset
//  I_req     in   1   cache request; read: held until last word; write: may be a 1-cycle pulse
//  I_addr    in   32  byte address (read: line base; write: byte address)
//  I_write   in   1   1 = write, 0 = read
//  I_in      in   32  write data, already byte-lane aligned
//  I_type    in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  I_out     out  32  read word, valid when I_wait=0 in R state
//  I_wait    out  1   0 = word delivered / write completed this cycle
//  bus_err   out  1   sticky: any RRESP/BRESP != OKAY
//  AW: AWID[ID_W] AWADDR[32] AWLEN[8] AWSIZE[3] AWBURST[2] AWVALID out; AWREADY in
//  W:  WDATA[32] WSTRB[4] WLAST WVALID out; WREADY in
//  B:  BID[ID_W] BRESP[2] BVALID in; BREADY out
//  AR: ARID[ID_W] ARADDR[32] ARLEN[8] ARSIZE[3] ARBURST[2] ARVALID out; ARREADY in
//  R:  RID[ID_W] RDATA[32] RRESP[2] RLAST RVALID in; RREADY out
// BEHAVIOUR
//  - Reset: FSM=IDLE, all VALID/READY=0, I_out=0, bus_err=0, beat cnt=0; async, aborts any txn.
//  - FSM: IDLE, AR, R, AWW, B.
//  - IDLE: I_wait = I_req (comb). I_req&~I_write -> latch {I_addr[31:4],4'h0}, go AR.
//    I_req&I_write -> latch addr/data/type, go AWW. No request accepted outside IDLE.
//  - AR: ARVALID=1, ARSIZE=2, ARBURST=INCR, ARID=MST_ID; held stable until ARREADY -> R.
//  - R: RREADY=1; I_out=RDATA, I_wait=~RVALID (comb); 0-latency, 1 word/cycle max.
//    Beat cnt 0..LINE_WORDS-1 increments per R handshake; last beat -> IDLE.
//    Last beat = cnt==LINE_WORDS-1; an RLAST mismatch sets bus_err, cnt governs.
//  - AWW: AWVALID and WVALID raised together; each dropped after its own handshake
//    (either order, same cycle allowed); both done -> B. AWADDR=latched addr, AWLEN=0,
//    AWSIZE=2, WLAST=1, WDATA=latched I_in. WSTRB: W 1111; H/HU 0011<<{a[1],0};
//    B/BU 0001<<a[1:0]; other type -> 0000 (txn still issued).
//  - B: BREADY=1; BVALID -> I_wait=0 that cycle, go IDLE.
//  - Outside IDLE and the delivery cycles above, I_wait=1; I_out=0 outside R.
//  - bus_err set on R/B handshake with RESP!=2'b00; cleared only by reset. Data is still delivered.
//  - Back-to-back: a request seen in IDLE the cycle after a return is accepted; no bubble needed.
//  - RID/BID ignored.
// CONFIGURATION
//  L1I_AXI_BURST_EN defined: one AR, ARLEN=LINE_WORDS-1, ARADDR=line base.
//  Undefined: LINE_WORDS single AR txns, ARLEN=0, ARADDR=base+4*cnt; after each non-last
//  beat FSM returns R->AR with the next address. Cache-side timing unchanged.
// TESTING
//  1 Reset: ARESETn=0 mid-idle -> all VALID/READY=0, bus_err=0; I_req=0 -> I_wait=0.
//  2 Read I_addr=0x1234 -> ARADDR=0x1230 ARLEN=3 ARSIZE=2; RDATA A0..A3 with gap cycles
//    -> I_wait low exactly 4 cycles, I_out=A0,A1,A2,A3, FSM returns IDLE.
//  3 Write byte a=0x2002, I_in=0x00AB0000 (1-cycle I_req) -> WSTRB=0100, AWREADY 2 cycles
//    before WREADY, BVALID after 3 -> single I_wait=0 cycle on B handshake.
//  4 RRESP=2'b10 on beat 2 -> word still delivered, bus_err=1 and stays 1 for later OKAY txns.
//  5 ARESETn pulse after beat 1 of burst -> RREADY/ARVALID 0 at once; next read issues fresh AR.
//  6 Macro undefined, read 0x1230 -> ARADDR 0x1230,0x1234,0x1238,0x123C, ARLEN=0 each, 4 words out.

Source files
------------

// File: rtl/l1i_axi_bridge_if.sv
// AXI4 master-side bus bundle between the L1I bridge and memory.
// The master modport is the bridge view, the slave modport the memory view.
interface l1i_axi_bridge_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] AWID;
    logic [31:0]     AWADDR;
    logic [7:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;

    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;

    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [7:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;

    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/l1i_axi_bridge.sv
// L1 instruction-cache memory-side bridge: cache word requests -> AXI4 reads/writes.
// Define L1I_AXI_BURST_EN to refill a line with one INCR burst instead of single-beat reads.
module l1i_axi_bridge #(
    parameter int            ID_W       = 4,
    parameter logic [ID_W-1:0] MST_ID   = '0,
    parameter int            LINE_WORDS = 4
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        I_req,
    input  logic [31:0] I_addr,
    input  logic        I_write,
    input  logic [31:0] I_in,
    input  logic [2:0]  I_type,
    output logic [31:0] I_out,
    output logic        I_wait,
    output logic        bus_err,
    l1i_axi_bridge_if.master axi
);
    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
`ifdef L1I_AXI_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             aw_done, w_done;
    logic [31:0]      addr_q, data_q;
    logic [2:0]       type_q;
    logic             r_fire, aw_fire, w_fire, b_fire, r_last, rlast_exp;
    logic             unused_ids;

    function automatic logic [3:0] wstrb_calc(input logic [2:0] t, input logic [1:0] a);
        logic [3:0] s;
        case (t)
            3'b010:         s = 4'b1111;
            3'b001, 3'b101: s = 4'b0011 << {a[1], 1'b0};
            3'b000, 3'b100: s = 4'b0001 << a;
            default:        s = 4'b0000;
        endcase
        return s;
    endfunction

    assign unused_ids = ^{axi.RID, axi.BID};

    assign r_last    = (cnt == CNT_W'(LINE_WORDS - 1));
    assign rlast_exp = BURST_EN ? r_last : 1'b1;
    assign r_fire    = (state == S_R) && axi.RVALID;
    assign aw_fire   = axi.AWVALID && axi.AWREADY;
    assign w_fire    = axi.WVALID && axi.WREADY;
    assign b_fire    = (state == S_B) && axi.BVALID;

    assign axi.AWID    = MST_ID;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = 8'd0;
    assign axi.AWSIZE  = 3'd2;
    assign axi.AWBURST = 2'b01;
    assign axi.WDATA   = data_q;
    assign axi.WSTRB   = wstrb_calc(type_q, addr_q[1:0]);
    assign axi.WLAST   = 1'b1;
    assign axi.ARID    = MST_ID;
    assign axi.ARSIZE  = 3'd2;
    assign axi.ARBURST = 2'b01;
    assign axi.ARLEN   = BURST_EN ? 8'(LINE_WORDS - 1) : 8'd0;
    // Single-beat refills walk the line one word per AR using the beat counter.
    assign axi.ARADDR  = BURST_EN ? addr_q : addr_q + {{(30-CNT_W){1'b0}}, cnt, 2'b00};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_AWW) begin
                if (state_nxt == S_B) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
            end
            if (r_fire) begin
                cnt <= r_last ? '0 : cnt + 1'b1;
                if (axi.RRESP != 2'b00 || axi.RLAST != rlast_exp) bus_err <= 1'b1;
            end
            if (b_fire && axi.BRESP != 2'b00) bus_err <= 1'b1;
        end
    end

    // Request payload is only meaningful while a transaction is in flight.
    always_ff @(posedge ACLK) begin
        if (state == S_IDLE && I_req) begin
            addr_q <= I_write ? I_addr : {I_addr[31:4], 4'h0};
            data_q <= I_in;
            type_q <= I_type;
        end
    end

    always_comb begin
        state_nxt   = state;
        I_wait      = 1'b1;
        I_out       = 32'd0;
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b0;
        axi.AWVALID = 1'b0;
        axi.WVALID  = 1'b0;
        axi.BREADY  = 1'b0;
        case (state)
            S_IDLE: begin
                I_wait = I_req;
                if (I_req) state_nxt = I_write ? S_AWW : S_AR;
            end
            S_AR: begin
                axi.ARVALID = 1'b1;
                if (axi.ARREADY) state_nxt = S_R;
            end
            S_R: begin
                axi.RREADY = 1'b1;
                I_out      = axi.RDATA;
                I_wait     = ~axi.RVALID;
                if (axi.RVALID) state_nxt = r_last ? S_IDLE : (BURST_EN ? S_R : S_AR);
            end
            S_AWW: begin
                axi.AWVALID = ~aw_done;
                axi.WVALID  = ~w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = S_B;
            end
            S_B: begin
                axi.BREADY = 1'b1;
                I_wait     = ~axi.BVALID;
                if (axi.BVALID) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_l1i_axi_bridge.sv
// Directed bench for l1i_axi_bridge: refills, write-throughs, error stickiness and resets.
module tb_l1i_axi_bridge;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        I_req = 1'b0;
    logic [31:0] I_addr = '0;
    logic        I_write = 1'b0;
    logic [31:0] I_in = '0;
    logic [2:0]  I_type = '0;
    logic [31:0] I_out;
    logic        I_wait;
    logic        bus_err;
    int          errors = 0;
    int          checks = 0;

`ifdef L1I_AXI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    l1i_axi_bridge_if #(.ID_W(4)) axi ();

    l1i_axi_bridge #(.ID_W(4), .MST_ID(4'h0), .LINE_WORDS(4)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .I_req   (I_req),
        .I_addr  (I_addr),
        .I_write (I_write),
        .I_in    (I_in),
        .I_type  (I_type),
        .I_out   (I_out),
        .I_wait  (I_wait),
        .bus_err (bus_err),
        .axi     (axi)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check1({tag, "_arvalid"}, axi.ARVALID, 1'b0);
        check1({tag, "_awvalid"}, axi.AWVALID, 1'b0);
        check1({tag, "_wvalid"},  axi.WVALID,  1'b0);
        check1({tag, "_rready"},  axi.RREADY,  1'b0);
        check1({tag, "_bready"},  axi.BREADY,  1'b0);
    endtask

    task automatic do_read(input logic [31:0] a, input int err_beat, input int abort_after);
        logic [31:0] base;
        logic [31:0] exp_ar;
        base   = {a[31:4], 4'h0};
        I_req  = 1'b1;
        I_write = 1'b0;
        I_addr = a;
        #1;
        check1("rd_req_wait", I_wait, 1'b1);
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b == 0 || !BURST) begin
                exp_ar = BURST ? base : base + 32'(4 * b);
                check1("ar_valid", axi.ARVALID, 1'b1);
                check("ar_addr", axi.ARADDR, exp_ar);
                check("ar_len", {24'd0, axi.ARLEN}, BURST ? 32'd3 : 32'd0);
                check("ar_size", {29'd0, axi.ARSIZE}, 32'd2);
                check("ar_burst", {30'd0, axi.ARBURST}, 32'd1);
                check("ar_id", {28'd0, axi.ARID}, 32'd0);
                check1("ar_wait", I_wait, 1'b1);
                check1("ar_rready", axi.RREADY, 1'b0);
                tick();
                check1("ar_hold_valid", axi.ARVALID, 1'b1);
                check("ar_hold_addr", axi.ARADDR, exp_ar);
                axi.ARREADY = 1'b1;
                tick();
                axi.ARREADY = 1'b0;
            end
            axi.RVALID = 1'b0;
            #1;
            check1("r_gap_rready", axi.RREADY, 1'b1);
            check1("r_gap_wait", I_wait, 1'b1);
            tick();
            axi.RVALID = 1'b1;
            axi.RDATA  = 32'hA000_0000 + 32'(b);
            axi.RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
            axi.RLAST  = BURST ? (b == 3) : 1'b1;
            #1;
            check1("r_beat_wait", I_wait, 1'b0);
            check("r_beat_data", I_out, 32'hA000_0000 + 32'(b));
            tick();
            axi.RVALID = 1'b0;
            axi.RLAST  = 1'b0;
            axi.RRESP  = 2'b00;
            if (b == abort_after) begin
                ARESETn = 1'b0;
                I_req   = 1'b0;
                #1;
                check1("abort_arvalid", axi.ARVALID, 1'b0);
                check1("abort_rready", axi.RREADY, 1'b0);
                check1("abort_wait", I_wait, 1'b0);
                ARESETn = 1'b1;
                return;
            end
        end
        I_req = 1'b0;
        #1;
        check_quiet("rd_done");
        check1("rd_done_wait", I_wait, 1'b0);
        check("rd_done_out", I_out, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                            input logic [3:0] strb, input int aw_d, input int w_d,
                            input int b_d, input logic [1:0] bresp);
        int last;
        last    = (aw_d > w_d) ? aw_d : w_d;
        I_req   = 1'b1;
        I_write = 1'b1;
        I_addr  = a;
        I_in    = d;
        I_type  = t;
        #1;
        check1("wr_req_wait", I_wait, 1'b1);
        tick();
        I_req   = 1'b0;
        I_write = 1'b0;
        for (int k = 0; k <= last; k++) begin
            axi.AWREADY = (k == aw_d);
            axi.WREADY  = (k == w_d);
            #1;
            check1("aw_valid", axi.AWVALID, k <= aw_d);
            check1("w_valid", axi.WVALID, k <= w_d);
            check1("aww_wait", I_wait, 1'b1);
            if (k == 0) begin
                check("aw_addr", axi.AWADDR, a);
                check("aw_len", {24'd0, axi.AWLEN}, 32'd0);
                check("aw_size", {29'd0, axi.AWSIZE}, 32'd2);
                check("w_data", axi.WDATA, d);
                check("w_strb", {28'd0, axi.WSTRB}, {28'd0, strb});
                check1("w_last", axi.WLAST, 1'b1);
            end
            tick();
        end
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        for (int j = 0; j <= b_d; j++) begin
            axi.BVALID = (j == b_d);
            axi.BRESP  = bresp;
            #1;
            check1("b_bready", axi.BREADY, 1'b1);
            check1("b_wait", I_wait, j != b_d);
            tick();
        end
        axi.BVALID = 1'b0;
        axi.BRESP  = 2'b00;
        #1;
        check_quiet("wr_done");
        check1("wr_done_wait", I_wait, 1'b0);
    endtask

    initial begin
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.BID = '0; axi.BRESP = 2'b00; axi.BVALID = 1'b0;
        axi.ARREADY = 1'b0;
        axi.RID = '0; axi.RDATA = '0; axi.RRESP = 2'b00; axi.RLAST = 1'b0; axi.RVALID = 1'b0;
        #1;
        check_quiet("rst");
        check1("rst_bus_err", bus_err, 1'b0);
        check1("rst_wait", I_wait, 1'b0);
        check("rst_out", I_out, 32'd0);
        tick();
        tick();
        ARESETn = 1'b1;
        tick();

        do_read(32'h0000_1234, -1, -1);
        check1("rd_ok_bus_err", bus_err, 1'b0);

        do_write(32'h0000_2002, 32'h00AB_0000, 3'b000, 4'b0100, 1, 3, 3, 2'b00);
        do_write(32'h0000_3000, 32'hDEAD_BEEF, 3'b010, 4'b1111, 0, 0, 0, 2'b00);
        do_write(32'h0000_3006, 32'h1234_0000, 3'b101, 4'b1100, 2, 0, 1, 2'b00);
        do_write(32'h0000_3001, 32'h0000_CD00, 3'b100, 4'b0010, 0, 1, 0, 2'b00);
        do_write(32'h0000_3000, 32'h0000_0001, 3'b011, 4'b0000, 0, 0, 0, 2'b00);
        check1("wr_ok_bus_err", bus_err, 1'b0);

        do_read(32'h0000_4000, 2, -1);
        check1("rresp_bus_err", bus_err, 1'b1);
        do_write(32'h0000_4004, 32'h5555_AAAA, 3'b010, 4'b1111, 0, 0, 1, 2'b00);
        check1("sticky_after_wr", bus_err, 1'b1);
        do_read(32'h0000_5008, -1, -1);
        check1("sticky_after_rd", bus_err, 1'b1);

        ARESETn = 1'b0;
        #1;
        check_quiet("idle_rst");
        check1("idle_rst_bus_err", bus_err, 1'b0);
        check1("idle_rst_wait", I_wait, 1'b0);
        ARESETn = 1'b1;
        tick();

        do_write(32'h0000_6000, 32'h0000_0000, 3'b010, 4'b1111, 0, 0, 0, 2'b01);
        check1("bresp_bus_err", bus_err, 1'b1);
        ARESETn = 1'b0;
        #1;
        ARESETn = 1'b1;
        tick();

        do_read(32'h0000_7000, -1, 1);
        tick();
        do_read(32'h0000_1230, -1, -1);
        check1("final_bus_err", bus_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
